// File: rtl/alu_pkg.sv
// Shared encodings for the multi-cycle ALU: opcodes, FSM states and compare flag positions.
package alu_pkg;

   localparam int unsigned OP_W = 2;

   typedef enum logic [OP_W-1:0] {
      OP_ADD = 2'b00,
      OP_SUB = 2'b01,
      OP_MUL = 2'b10,
      OP_DIV = 2'b11
   } alu_op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_ITER = 2'b01,
      S_DONE = 2'b10
   } alu_state_e;

   localparam int unsigned FLAG_N = 2;
   localparam int unsigned FLAG_Z = 1;
   localparam int unsigned FLAG_P = 0;

   function automatic logic is_iterative(input alu_op_e op);
      return (op == OP_MUL) || (op == OP_DIV);
   endfunction

endpackage

// File: rtl/alu_seq_muldiv.sv
// Iterative datapath: shift-add multiply (low WIDTH bits) and restoring unsigned divide, one bit per step.
module alu_seq_muldiv
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             op_is_div,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             step,
   output logic [WIDTH-1:0] out,
   output logic             last
);

   localparam int unsigned CW = $clog2(WIDTH + 1);

   // acc: product accumulator or partial remainder; opa: multiplier or dividend/quotient shifter
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] opa;
   logic [WIDTH-1:0] opb;
   logic [CW-1:0]    count;
   logic             is_div;

   logic [WIDTH-1:0] acc_mul;
   logic [WIDTH-1:0] acc_div;
   logic [WIDTH-1:0] opa_div;
   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   trial;

   // Next-step values; a negative trial (top bit set) restores the shifted remainder
   always_comb begin
      acc_mul = acc + (opa[0] ? opb : '0);
      shifted = {acc, opa[WIDTH-1]};
      trial   = shifted - {1'b0, opb};
      acc_div = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
      opa_div = {opa[WIDTH-2:0], ~trial[WIDTH]};
   end

   // Result as it will stand after the current step, so the final step can be committed directly
   assign out  = is_div ? opa_div : acc_mul;
   assign last = (count == CW'(1));

   always_ff @(posedge clk) begin
      if (reset) begin
         acc    <= '0;
         opa    <= '0;
         opb    <= '0;
         count  <= '0;
         is_div <= 1'b0;
      end else if (load) begin
         acc    <= '0;
         opa    <= a;
         opb    <= b;
         count  <= CW'(WIDTH);
         is_div <= op_is_div;
      end else if (step && (count != '0)) begin
         count <= count - CW'(1);
         if (is_div) begin
            acc <= acc_div;
            opa <= opa_div;
         end else begin
            acc <= acc_mul;
            opa <= opa >> 1;
            opb <= opb << 1;
         end
      end
   end

endmodule

// File: rtl/alu_multicycle.sv
// Per-thread ALU: single-cycle ADD/SUB/compare, iterative MUL/DIV, start/busy/done handshake.
module alu_multicycle
   import alu_pkg::*;
#(
   parameter int unsigned      WIDTH      = 8,
   parameter logic [WIDTH-1:0] DIV0_VALUE = '1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             start,
   input  logic [1:0]       decoded_alu_arithmetic_mux,
   input  logic             decoded_alu_output_mux,
   input  logic [WIDTH-1:0] rs,
   input  logic [WIDTH-1:0] rt,
   output logic [WIDTH-1:0] alu_out,
   output logic             busy,
   output logic             done
);

   alu_state_e       state;
   alu_state_e       state_next;
   alu_op_e          op;
   logic             accept;
   logic             md_load;
   logic             md_step;
   logic             md_last;
   logic [WIDTH-1:0] md_out;
   logic             out_we;
   logic [WIDTH-1:0] out_next;
   logic [WIDTH-1:0] cmp_flags;
   logic             div0;

   assign op     = alu_op_e'(decoded_alu_arithmetic_mux);
   assign accept = start && enable && (state == S_IDLE);

   // Unsigned compare produces exactly one of N/Z/P
   always_comb begin
      cmp_flags         = '0;
      cmp_flags[FLAG_N] = (rs < rt);
      cmp_flags[FLAG_Z] = (rs == rt);
      cmp_flags[FLAG_P] = (rs > rt);
   end

   always_comb begin
      state_next = state;
      md_load    = 1'b0;
      md_step    = 1'b0;
      out_we     = 1'b0;
      out_next   = alu_out;
      case (state)
         S_IDLE: begin
            if (accept) begin
               if (decoded_alu_output_mux) begin
                  out_we     = 1'b1;
                  out_next   = cmp_flags;
                  state_next = S_DONE;
               end else if (is_iterative(op)) begin
                  md_load    = 1'b1;
                  state_next = S_ITER;
               end else begin
                  out_we     = 1'b1;
                  out_next   = (op == OP_SUB) ? (rs - rt) : (rs + rt);
                  state_next = S_DONE;
               end
            end
         end
         S_ITER: begin
            md_step = 1'b1;
            if (md_last) begin
               out_we     = 1'b1;
               out_next   = div0 ? DIV0_VALUE : md_out;
               state_next = S_DONE;
            end
         end
         S_DONE:  state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   // busy/done are registered decodes of the upcoming state
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_next;
         busy  <= (state_next == S_ITER);
         done  <= (state_next == S_DONE);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         alu_out <= '0;
         div0    <= 1'b0;
      end else begin
         if (out_we) begin
            alu_out <= out_next;
         end
         if (md_load) begin
            div0 <= (op == OP_DIV) && (rt == '0);
         end
      end
   end

   alu_seq_muldiv #(
      .WIDTH(WIDTH)
   ) u_muldiv (
      .clk       (clk),
      .reset     (reset),
      .load      (md_load),
      .op_is_div (op == OP_DIV),
      .a         (rs),
      .b         (rt),
      .step      (md_step),
      .out       (md_out),
      .last      (md_last)
   );

endmodule

// File: tb/tb_alu_multicycle.sv
// Scoreboard bench for alu_multicycle at WIDTH=8 and WIDTH=16 against an arithmetic reference model.
module tb_alu_multicycle;

   typedef struct {
      logic [63:0] val;
      int          due;
   } exp_t;

   logic        clk   = 1'b0;
   logic        reset = 1'b1;

   logic        en8 = 1'b0, st8 = 1'b0, cm8 = 1'b0;
   logic [1:0]  op8 = '0;
   logic [7:0]  rs8 = '0, rt8 = '0, out8;
   logic        busy8, done8;

   logic        en16 = 1'b0, st16 = 1'b0, cm16 = 1'b0;
   logic [1:0]  op16 = '0;
   logic [15:0] rs16 = '0, rt16 = '0, out16;
   logic        busy16, done16;

   exp_t        sb8[$];
   exp_t        sb16[$];
   int          cyc      = 0;
   int          n_checks = 0;
   int          n_fail   = 0;
   int          free_c[2] = '{0, 0};
   int          blo[2]    = '{0, 0};
   int          bhi[2]    = '{0, 0};
   logic [63:0] held[2]   = '{64'd0, 64'd0};
   logic        rst_prev  = 1'b0;

   alu_multicycle #(.WIDTH(8)) u_dut8 (
      .clk                        (clk),
      .reset                      (reset),
      .enable                     (en8),
      .start                      (st8),
      .decoded_alu_arithmetic_mux (op8),
      .decoded_alu_output_mux     (cm8),
      .rs                         (rs8),
      .rt                         (rt8),
      .alu_out                    (out8),
      .busy                       (busy8),
      .done                       (done8)
   );

   alu_multicycle #(.WIDTH(16)) u_dut16 (
      .clk                        (clk),
      .reset                      (reset),
      .enable                     (en16),
      .start                      (st16),
      .decoded_alu_arithmetic_mux (op16),
      .decoded_alu_output_mux     (cm16),
      .rs                         (rs16),
      .rt                         (rt16),
      .alu_out                    (out16),
      .busy                       (busy16),
      .done                       (done16)
   );

   initial forever #5 clk = ~clk;
   initial forever begin
      @(posedge clk);
      cyc++;
   end

   function automatic logic [63:0] ref_alu(input int w, input logic [1:0] op, input logic cm,
                                            input logic [63:0] a_in, input logic [63:0] b_in);
      logic [63:0] mask;
      logic [63:0] a;
      logic [63:0] b;
      mask = (64'd1 << w) - 64'd1;
      a    = a_in & mask;
      b    = b_in & mask;
      if (cm) return (a < b) ? 64'd4 : ((a == b) ? 64'd2 : 64'd1);
      case (op)
         2'd0:    return (a + b) & mask;
         2'd1:    return (a - b) & mask;
         2'd2:    return (a * b) & mask;
         default: return (b == 64'd0) ? mask : (a / b);
      endcase
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
      end
   endtask

   task automatic check_lane(input int lane, input logic [63:0] out, input logic bsy, input logic dn);
      exp_t e;
      int   n;
      n = (lane == 0) ? sb8.size() : sb16.size();
      chk($sformatf("lane%0d_busy", lane), 64'(bsy), 64'(cyc > blo[lane] && cyc <= bhi[lane]));
      if (dn === 1'b1) begin
         if (n == 0) begin
            chk($sformatf("lane%0d_unexpected_done", lane), 64'(dn), 64'd0);
         end else begin
            if (lane == 0) e = sb8.pop_front();
            else           e = sb16.pop_front();
            chk($sformatf("lane%0d_result", lane), out, e.val);
            chk($sformatf("lane%0d_done_cycle", lane), 64'(cyc), 64'(e.due));
            held[lane] = e.val;
         end
      end else begin
         chk($sformatf("lane%0d_done_low", lane), 64'(dn), 64'd0);
         chk($sformatf("lane%0d_hold", lane), out, held[lane]);
         if (n > 0) begin
            e = (lane == 0) ? sb8[0] : sb16[0];
            if (cyc > e.due) begin
               chk($sformatf("lane%0d_timeout", lane), 64'(cyc), 64'(e.due));
               if (lane == 0) void'(sb8.pop_front());
               else           void'(sb16.pop_front());
            end
         end
      end
   endtask

   // Monitor: samples on the falling edge, independent of stimulus
   initial forever begin
      @(negedge clk);
      if (rst_prev) begin
         chk("reset_out", 64'(out8), 64'd0);
         chk("reset_busy", 64'(busy8), 64'd0);
         chk("reset_done", 64'(done8), 64'd0);
         sb8.delete();
         held[0] = 64'd0;
      end else begin
         check_lane(0, 64'(out8), busy8, done8);
      end
      check_lane(1, 64'(out16), busy16, done16);
      rst_prev = reset;
   end

   task automatic scramble();
      en8  = 1'($urandom_range(0, 1));
      en16 = 1'($urandom_range(0, 1));
      op8  = 2'($urandom);
      op16 = 2'($urandom);
      cm8  = 1'($urandom);
      cm16 = 1'($urandom);
      rs8  = 8'($urandom);
      rt8  = 8'($urandom);
      rs16 = 16'($urandom);
      rt16 = 16'($urandom);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         st8  = 1'b0;
         st16 = 1'b0;
         scramble();
      end
   endtask

   task automatic issue(input int lane, input logic [1:0] op, input logic cm,
                        input int unsigned a, input int unsigned b, input logic en);
      int   c;
      int   w;
      int   lat;
      exp_t e;
      w = (lane == 0) ? 8 : 16;
      @(posedge clk);
      #1;
      c = cyc;
      if (lane == 0) begin
         en8 = en; st8 = 1'b1; op8 = op; cm8 = cm; rs8 = 8'(a); rt8 = 8'(b);
      end else begin
         en16 = en; st16 = 1'b1; op16 = op; cm16 = cm; rs16 = 16'(a); rt16 = 16'(b);
      end
      lat = (cm || op < 2'd2) ? 1 : w + 1;
      if (en && c >= free_c[lane]) begin
         e.val = ref_alu(w, op, cm, 64'(a), 64'(b));
         e.due = c + lat;
         if (lane == 0) sb8.push_back(e);
         else           sb16.push_back(e);
         free_c[lane] = c + lat + 1;
         if (lat > 1) begin
            blo[lane] = c;
            bhi[lane] = c + w;
         end
      end
      @(posedge clk);
      #1;
      st8  = 1'b0;
      st16 = 1'b0;
      scramble();
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      reset = 1'b1;
      for (int l = 0; l < 2; l++) if (bhi[l] > cyc) bhi[l] = cyc;
      @(posedge clk);
      #1;
      reset     = 1'b0;
      free_c[0] = cyc;
      free_c[1] = cyc;
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      reset     = 1'b0;
      free_c[0] = cyc;
      free_c[1] = cyc;

      issue(0, 2'd0, 1'b0, 200, 100, 1'b1); idle(1);
      issue(0, 2'd1, 1'b0, 5, 7, 1'b1);     idle(1);
      issue(0, 2'd0, 1'b1, 3, 9, 1'b1);
      issue(0, 2'd2, 1'b1, 9, 9, 1'b1);
      issue(0, 2'd3, 1'b1, 10, 9, 1'b1);
      issue(0, 2'd2, 1'b0, 13, 11, 1'b1);   idle(8);
      issue(0, 2'd2, 1'b0, 20, 20, 1'b1);   idle(8);
      issue(0, 2'd3, 1'b0, 100, 7, 1'b1);   idle(8);
      issue(0, 2'd3, 1'b0, 100, 0, 1'b1);   idle(8);
      // Second start during ITER must be dropped
      issue(0, 2'd2, 1'b0, 13, 11, 1'b1);   idle(1);
      issue(0, 2'd0, 1'b0, 1, 2, 1'b1);     idle(8);
      issue(0, 2'd0, 1'b0, 3, 4, 1'b0);     idle(2);
      // Reset in the middle of a divide, then a fresh add
      issue(0, 2'd3, 1'b0, 100, 7, 1'b1);   idle(2);
      do_reset();
      issue(0, 2'd0, 1'b0, 1, 1, 1'b1);     idle(2);

      for (int i = 0; i < 150; i++) begin
         if ($urandom_range(0, 39) == 0) do_reset();
         issue(0, 2'($urandom), ($urandom_range(0, 3) == 0), $urandom_range(0, 255),
               ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 255), ($urandom_range(0, 7) != 0));
         idle($urandom_range(0, 11));
      end
      idle(12);

      issue(1, 2'd3, 1'b0, 60000, 3, 1'b1); idle(16);
      issue(1, 2'd2, 1'b0, 300, 300, 1'b1); idle(16);
      issue(1, 2'd3, 1'b0, 1234, 0, 1'b1);  idle(16);
      for (int i = 0; i < 30; i++) begin
         issue(1, 2'($urandom), ($urandom_range(0, 3) == 0), $urandom_range(0, 65535),
               ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 65535), ($urandom_range(0, 7) != 0));
         idle($urandom_range(0, 19));
      end
      idle(20);

      chk("drain8", 64'(sb8.size()), 64'd0);
      chk("drain16", 64'(sb16.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
